// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

    localparam int unsigned STAGE_W = 3;

    typedef enum logic [2:0] {
        S_RESET,
        S_HOLD,
        S_WAIT,
        S_READY,
        S_FAIL
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned tmo);
        int unsigned m;
        m = (hold > tmo) ? hold : tmo;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_bridge.sv
// Async-assert / sync-deassert bridge: brdy rises DEPTH edges after arst is released.
module rst_bridge #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic arst,
    output logic brdy
);

    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], 1'b1};
        end
    end

    assign brdy = r_sync[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-domain resets in index order, waiting for each domain's init-done
// before releasing the next; supports soft re-sequence and per-domain timeout.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  all_ready,
    output logic                  timeout_err,
    output logic [STAGE_W-1:0]    fail_stage,
    output logic [STAGE_W-1:0]    cur_stage
);

    localparam int unsigned CNT_W     = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
    // Compare against the pre-increment value so the edge that makes the count reach N-1 acts.
    localparam int unsigned HOLD_LAST = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0;
    localparam int unsigned TMO_LAST  = TIMEOUT_CYCLES - 2;

    state_e                r_state, w_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic [NUM_STAGES-1:0] r_rst, w_rst;
    logic                  r_ready, w_ready;
    logic                  r_tmo, w_tmo;
    logic [STAGE_W-1:0]    r_fail, w_fail;
    logic [STAGE_W-1:0]    r_cur, w_cur;
    logic                  w_brdy;
    logic                  w_done;

    rst_bridge #(
        .DEPTH (SYNC_STAGES)
    ) u_bridge (
        .clk  (clk),
        .arst (arst),
        .brdy (w_brdy)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_tmo   <= 1'b0;
            r_fail  <= '0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_rst   <= w_rst;
            r_ready <= w_ready;
            r_tmo   <= w_tmo;
            r_fail  <= w_fail;
            r_cur   <= w_cur;
        end
    end

    always_comb begin
        w_done = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_cur == STAGE_W'(i)) begin
                w_done = stage_done[i];
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_rst   = r_rst;
        w_ready = r_ready;
        w_tmo   = r_tmo;
        w_fail  = r_fail;
        w_cur   = r_cur;

        if (soft_rst_req && (r_state != S_RESET)) begin
            w_state = S_HOLD;
            w_cnt   = '0;
            w_rst   = '1;
            w_ready = 1'b0;
            w_tmo   = 1'b0;
            w_fail  = '0;
            w_cur   = '0;
        end else begin
            unique case (r_state)
                S_RESET: begin
                    w_rst = '1;
                    w_cnt = '0;
                    if (w_brdy) begin
                        w_state = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_LAST)) begin
                        w_rst[0] = 1'b0;
                        w_cnt    = '0;
                        w_cur    = '0;
                        w_state  = S_WAIT;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // A done on the timeout edge still counts as a success.
                    if (w_done) begin
                        w_cnt = '0;
                        if (r_cur == STAGE_W'(NUM_STAGES - 1)) begin
                            w_state = S_READY;
                            w_ready = 1'b1;
                            w_cur   = STAGE_W'(NUM_STAGES);
                        end else begin
                            w_cur = r_cur + STAGE_W'(1);
                            for (int i = 1; i < NUM_STAGES; i++) begin
                                if (r_cur == STAGE_W'(i - 1)) begin
                                    w_rst[i] = 1'b0;
                                end
                            end
                        end
                    end else if (r_cnt == CNT_W'(TMO_LAST)) begin
                        w_state = S_FAIL;
                        w_cnt   = '0;
                        w_rst   = '1;
                        w_tmo   = 1'b1;
                        w_fail  = r_cur;
                        w_ready = 1'b0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_READY: begin
                    w_cnt = '0;
                end
                S_FAIL: begin
                    w_cnt   = '0;
                    w_rst   = '1;
                    w_tmo   = 1'b1;
                    w_ready = 1'b0;
                end
                default: begin
                    w_state = S_RESET;
                    w_rst   = '1;
                end
            endcase
        end
    end

    assign rst_out     = r_rst;
    assign all_ready   = r_ready;
    assign timeout_err = r_tmo;
    assign fail_stage  = r_fail;
    assign cur_stage   = r_cur;

endmodule
